multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have these inputs: OP  in  6  opcode from IR, valid from DECODE; Zero  in  1  ALU zero flag; MemReady  in  1  memory access complete.
REQ-003 SHALL have these 1-bit outputs: PCWrite  out  1; IorD  out  1 (0=PC, 1=ALUOut); MemRead  out  1; MemWrite  out  1; IRWrite  out  1; RegWrite  out  1; ALUSrcA  out  1 (0=PC, 1=A).
REQ-004 SHALL have these 2-bit outputs: RegDst  out  2 (00 rt, 01 rd, 10 $31); MemtoReg  out  2 (00 ALUOut, 01 MDR, 10 PC, 11 imm<<16); ALUSrcB  out  2 (00 B, 01 const 4, 10 sext imm, 11 sext imm<<2); PCSource  out  2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-005 SHALL have these remaining outputs: ALUOp  out  3 (100 add, 101 or, 110 and, 001 sub, 111 R-type funct, 000 idle); State  out  4 (current state, debug); IllegalOp  out  1 (one-cycle pulse).

Function
REQ-006 SHALL support these opcodes: R-type 0x00, ADDI 0x08, ANDI 0x0c, ORI 0x0d, LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, LUI 0x0f.
REQ-007 SHALL use these states and encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, RTWB 7, ITEXEC 8, ITWB 9, BRANCH 10, JUMP 11, JAL 12, LUI 13. Codes 14 and 15 SHALL go to FETCH.
REQ-008 SHALL drive 0 on every output not listed for the current state.
REQ-009 FETCH: SHALL drive IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00. IRWrite=1 and PCWrite=1 SHALL be asserted only in the cycle MemReady=1, and the FSM SHALL then go to DECODE. With MemReady=0, the FSM SHALL stay in FETCH.
REQ-010 DECODE: SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=100. Next state by OP: LW/SW to MEMADDR; R-type to RTEXEC; ADDI/ANDI/ORI to ITEXEC; BEQ/BNE to BRANCH; J to JUMP; JAL to JAL; LUI to LUI.
REQ-011 DECODE with an unsupported OP: SHALL pulse IllegalOp for that cycle and go to FETCH; the instruction is skipped.
REQ-012 MEMADDR: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=100, then go to MEMRD for LW or MEMWR for SW.
REQ-013 MEMRD: SHALL drive IorD=1 and MemRead=1, holding them until MemReady=1, then go to MEMWB. MEMWB: SHALL drive RegDst=00, MemtoReg=01, RegWrite=1, then go to FETCH.
REQ-014 MEMWR: SHALL drive IorD=1 and MemWrite=1, holding them until MemReady=1, then go to FETCH.
REQ-015 RTEXEC: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=111. RTWB: SHALL drive RegDst=01, MemtoReg=00, RegWrite=1, then go to FETCH.
REQ-016 ITEXEC: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=100/110/101 for ADDI/ANDI/ORI. ITWB: SHALL drive RegDst=00, MemtoReg=00, RegWrite=1.
REQ-017 BRANCH: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01. PCWrite SHALL be Zero for BEQ and ~Zero for BNE (combinational in that cycle).
REQ-018 JUMP: SHALL drive PCSource=10 and PCWrite=1. JAL: SHALL drive PCSource=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1; the link value is the already-incremented PC.
REQ-019 LUI: SHALL drive RegDst=00, MemtoReg=11, RegWrite=1.
REQ-020 States BRANCH, JUMP, JAL, LUI, MEMWB, ITWB and RTWB SHALL return to FETCH.
REQ-021 With zero-wait memory, cycle counts SHALL be: J/JAL/LUI/BEQ/BNE 3; R-type/I-type/SW 4; LW 5. Each wait cycle SHALL add 1.
REQ-022 MemReady SHALL be ignored in states that issue no memory request.
REQ-023 Zero SHALL be ignored outside BRANCH.
REQ-024 All outputs are Moore decodes of State, except PCWrite/IRWrite in FETCH and PCWrite in BRANCH.

Reset
REQ-025 When reset=1 at a clk edge, the state SHALL become FETCH, regardless of current state or a pending MemReady.
REQ-026 While reset=1, all outputs SHALL be forced to 0 (State=0, MemRead=0); the first fetch request SHALL be issued in the cycle after reset deasserts.
REQ-027 Reset mid-access SHALL abandon the access; no RegWrite, PCWrite or MemWrite SHALL be issued for the abandoned access.

Structure
REQ-028 Opcode constants, ALUOp codes, mux-select encodings and state encodings SHALL live in the shared package mips_pkg, which the single-cycle decoder SHALL also use.
REQ-029 SHALL be one module containing a state register and a combinational next-state/output block; no sub-module is required.

Verification
REQ-030 Reset then R-type (OP=0x00), MemReady=1 constant -> States 0,1,6,7,0; RegWrite=1 with RegDst=01 only in RTWB.
REQ-031 LW (0x23) with MemReady low for 2 cycles in MEMRD -> MemRead/IorD=1 held 3 cycles; MEMWB asserts RegWrite with MemtoReg=01; total 7 cycles.
REQ-032 BEQ with Zero=1, then BNE with Zero=1 -> PCWrite=1 in BRANCH for BEQ; PCWrite=0 for BNE.
REQ-033 JAL (0x03) -> in State 12, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10.
REQ-034 OP=0x3f in DECODE -> IllegalOp=1 for one cycle, next State=0, no RegWrite, no PCWrite.
REQ-035 reset=1 asserted while in MEMWR waiting on MemReady -> next cycle State=0, MemWrite=0, all outputs 0 while reset is held.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, ALU operations, mux selects, and multicycle states.
// Both the single-cycle and multicycle decoders import this package.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXEC  = 4'd6,
        S_RTWB    = 4'd7,
        S_ITEXEC  = 4'd8,
        S_ITWB    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_LUI     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALU_IDLE  = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_LUI    = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Dispatch target out of DECODE; unsupported opcodes fall back to FETCH.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:             return S_MEMADDR;
            OP_RTYPE:                 return S_RTEXEC;
            OP_ADDI, OP_ANDI, OP_ORI: return S_ITEXEC;
            OP_BEQ, OP_BNE:           return S_BRANCH;
            OP_J:                     return S_JUMP;
            OP_JAL:                   return S_JAL;
            OP_LUI:                   return S_LUI;
            default:                  return S_FETCH;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and emits datapath controls, stalling on MemReady during memory accesses.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;

    // State register; OP is captured in DECODE since the IR field is only trusted there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_op    <= OP_RTYPE;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op <= OP;
        end
    end

    // Next-state and control decode; reset forces every output low.
    always_comb begin
        w_next    = S_FETCH;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        RegDst    = RD_RT;
        MemtoReg  = M2R_ALUOUT;
        ALUSrcB   = SRCB_B;
        PCSource  = PCS_ALU;
        ALUOp     = ALU_IDLE;
        IllegalOp = 1'b0;
        State     = r_state;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_4;
                ALUOp   = ALU_ADD;
                IRWrite = MemReady;
                PCWrite = MemReady;
                w_next  = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMMSH;
                ALUOp     = ALU_ADD;
                IllegalOp = !is_legal(OP);
                w_next    = decode_next(OP);
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
                w_next  = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                w_next  = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = MemReady ? S_FETCH : S_MEMWR;
            end
            S_RTEXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                w_next  = S_RTWB;
            end
            S_RTWB: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_ITEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = (r_op == OP_ANDI) ? ALU_AND :
                          (r_op == OP_ORI)  ? ALU_OR  : ALU_ADD;
                w_next  = S_ITWB;
            end
            S_ITWB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = PCS_ALUOUT;
                PCWrite  = (r_op == OP_BNE) ? !Zero : Zero;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
                RegDst   = RD_RA;
                MemtoReg = M2R_PC;
                RegWrite = 1'b1;
            end
            S_LUI: begin
                MemtoReg = M2R_LUI;
                RegWrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (reset) begin
            PCWrite   = 1'b0;
            IorD      = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = 1'b0;
            RegDst    = 2'b00;
            MemtoReg  = 2'b00;
            ALUSrcB   = 2'b00;
            PCSource  = 2'b00;
            ALUOp     = 3'b000;
            IllegalOp = 1'b0;
            State     = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares State plus the packed control word against hand-built values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic       IllegalOp;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .State(State), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    logic [18:0] w_outs;
    assign w_outs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                     ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp,
                     IllegalOp};

    // pcw iord mr mw irw rw asa rd m2r asb pcs aluop ill
    function automatic logic [18:0] mk(
        input logic pcw, input logic iord, input logic mr, input logic mw,
        input logic irw, input logic rw, input logic asa,
        input logic [1:0] rd, input logic [1:0] m2r, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [2:0] alu, input logic ill);
        return {pcw, iord, mr, mw, irw, rw, asa, rd, m2r, asb, pcs, alu, ill};
    endfunction

    logic [18:0] F_RDY, F_WAIT, DEC, DEC_ILL, MADDR, MRD, MWB, MWR;
    logic [18:0] RTEX, RTWB, ITADD, ITAND, ITOR, ITWB;
    logic [18:0] BR_T, BR_N, JMP, JALS, LUIS;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Check state and controls at this negedge, then advance one cycle.
    task automatic st(input string tag, input logic [3:0] es,
                      input logic [18:0] eo);
        #1;
        chk({tag, "_st"}, {28'd0, State}, {28'd0, es});
        chk({tag, "_out"}, {13'd0, w_outs}, {13'd0, eo});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        F_RDY   = mk(1,0,1,0,1,0,0,2'b00,2'b00,2'b01,2'b00,3'b100,0);
        F_WAIT  = mk(0,0,1,0,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b100,0);
        DEC     = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,2'b00,3'b100,0);
        DEC_ILL = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b11,2'b00,3'b100,1);
        MADDR   = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b100,0);
        MRD     = mk(0,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        MWB     = mk(0,0,0,0,0,1,0,2'b00,2'b01,2'b00,2'b00,3'b000,0);
        MWR     = mk(0,1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        RTEX    = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b111,0);
        RTWB    = mk(0,0,0,0,0,1,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
        ITADD   = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b100,0);
        ITAND   = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b110,0);
        ITOR    = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b10,2'b00,3'b101,0);
        ITWB    = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        BR_T    = mk(1,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b001,0);
        BR_N    = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b001,0);
        JMP     = mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,3'b000,0);
        JALS    = mk(1,0,0,0,0,1,0,2'b10,2'b10,2'b00,2'b10,3'b000,0);
        LUIS    = mk(0,0,0,0,0,1,0,2'b00,2'b11,2'b00,2'b00,3'b000,0);

        reset = 1'b1; OP = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        st("rst", 4'd0, 19'd0);
        reset = 1'b0;

        // R-type, zero-wait
        st("rt_f", 4'd0, F_RDY);
        st("rt_d", 4'd1, DEC);
        OP = 6'h3f;
        st("rt_ex", 4'd6, RTEX);
        st("rt_wb", 4'd7, RTWB);

        // LW with two wait cycles in MEMRD
        OP = 6'h23;
        st("lw_f", 4'd0, F_RDY);
        st("lw_d", 4'd1, DEC);
        MemReady = 1'b0;
        st("lw_a", 4'd2, MADDR);
        st("lw_r0", 4'd3, MRD);
        st("lw_r1", 4'd3, MRD);
        MemReady = 1'b1;
        st("lw_r2", 4'd3, MRD);
        st("lw_wb", 4'd4, MWB);

        // BEQ taken, then BNE with Zero=1 not taken
        OP = 6'h04; Zero = 1'b1;
        st("beq_f", 4'd0, F_RDY);
        st("beq_d", 4'd1, DEC);
        st("beq_br", 4'd10, BR_T);
        OP = 6'h05;
        st("bne_f", 4'd0, F_RDY);
        st("bne_d", 4'd1, DEC);
        st("bne_br", 4'd10, BR_N);
        Zero = 1'b0;

        // JAL, J, LUI
        OP = 6'h03;
        st("jal_f", 4'd0, F_RDY);
        st("jal_d", 4'd1, DEC);
        st("jal_x", 4'd12, JALS);
        OP = 6'h02;
        st("j_f", 4'd0, F_RDY);
        st("j_d", 4'd1, DEC);
        st("j_x", 4'd11, JMP);
        OP = 6'h0f;
        st("lui_f", 4'd0, F_RDY);
        st("lui_d", 4'd1, DEC);
        st("lui_x", 4'd13, LUIS);

        // I-type ALU variants
        OP = 6'h08;
        st("addi_f", 4'd0, F_RDY);
        st("addi_d", 4'd1, DEC);
        st("addi_x", 4'd8, ITADD);
        st("addi_wb", 4'd9, ITWB);
        OP = 6'h0c;
        st("andi_f", 4'd0, F_RDY);
        st("andi_d", 4'd1, DEC);
        st("andi_x", 4'd8, ITAND);
        st("andi_wb", 4'd9, ITWB);
        OP = 6'h0d;
        st("ori_f", 4'd0, F_RDY);
        st("ori_d", 4'd1, DEC);
        st("ori_x", 4'd8, ITOR);
        st("ori_wb", 4'd9, ITWB);

        // SW zero-wait
        OP = 6'h2b;
        st("sw_f", 4'd0, F_RDY);
        st("sw_d", 4'd1, DEC);
        st("sw_a", 4'd2, MADDR);
        st("sw_w", 4'd5, MWR);

        // Illegal opcode is skipped
        OP = 6'h3f;
        st("ill_f", 4'd0, F_RDY);
        st("ill_d", 4'd1, DEC_ILL);
        MemReady = 1'b0;
        st("ill_nx", 4'd0, F_WAIT);

        // Fetch wait states
        st("fw_1", 4'd0, F_WAIT);
        MemReady = 1'b1;
        OP = 6'h2b;
        st("fw_f", 4'd0, F_RDY);

        // Reset while MEMWR is stalled
        st("swr_d", 4'd1, DEC);
        MemReady = 1'b0;
        st("swr_a", 4'd2, MADDR);
        st("swr_w", 4'd5, MWR);
        reset = 1'b1; MemReady = 1'b1;
        st("swr_rst0", 4'd0, 19'd0);
        st("swr_rst1", 4'd0, 19'd0);
        reset = 1'b0;
        st("post_f", 4'd0, F_RDY);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
